fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing one bypass_fifo input, range 2..8.
REQ-002 Parameter WIDTH, default 128: data width per beat.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive beats granted to one requester while others wait, range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 req_valid  input  REQ_NUM  per-requester beat valid; held until accepted.
REQ-007 req_data  input  REQ_NUM*WIDTH  per-requester beat data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_power  input  REQ_NUM  per-requester keep flag, forwarded unchanged; 0 marks a beat the FIFO discards.
REQ-009 req_ready  output  REQ_NUM  per-requester accept; at most one bit high per cycle.
REQ-010 data_in_valid  output  1  beat valid toward the FIFO.
REQ-011 data_in  output  WIDTH  beat data toward the FIFO.
REQ-012 data_in_power  output  1  keep flag toward the FIFO.
REQ-013 data_in_ready  input  1  FIFO accept.
REQ-014 grant_id  output  $clog2(REQ_NUM)  index of the requester whose beat was most recently accepted.

Function
REQ-015 Output stage is one register slot; load_en = ~data_in_valid | data_in_ready.
REQ-016 A requester beat transfers when req_valid[i] & req_ready[i]; req_ready[i] = load_en & grant[i], combinational, with grant a function of req_valid and registered state only.
REQ-017 An accepted beat appears on data_in/data_in_power with data_in_valid=1 on the next cycle (latency 1); one beat per cycle throughput when data_in_ready stays 1.
REQ-018 While data_in_valid=1 & data_in_ready=0, data_in, data_in_power and data_in_valid remain unchanged.
REQ-019 When load_en=1 and no req_valid is set, data_in_valid drops to 0 at the next cycle if the slot is drained.
REQ-020 Arbitration state: holder (index), burst_cnt (0..MAX_BURST), rr_ptr (index of next-priority requester).
REQ-021 Holder keeps grant when req_valid[holder]=1 and burst_cnt<MAX_BURST.
REQ-022 Otherwise grant goes to the first valid requester searching rr_ptr, rr_ptr+1, ... modulo REQ_NUM, skipping holder if burst_cnt=MAX_BURST and any other requester is valid.
REQ-023 If holder is the only valid requester at burst_cnt=MAX_BURST, it is re-granted and burst_cnt restarts at 1.
REQ-024 On each accepted beat: if granted index equals holder and burst not restarted, burst_cnt increments; else holder<=granted index, burst_cnt<=1, rr_ptr<=granted index+1 modulo REQ_NUM.
REQ-025 When req_valid[holder]=0 in a cycle with load_en=1, burst_cnt clears to 0; holder and rr_ptr are unchanged.
REQ-026 When load_en=0, grant, holder, burst_cnt and rr_ptr are unchanged and all req_ready are 0.
REQ-027 Beats with req_power=0 are arbitrated, counted in burst_cnt and forwarded identically to power=1 beats.
REQ-028 grant_id updates to the granted index on each accepted beat, else holds.

Reset
REQ-029 While rst_n=0: data_in_valid=0, data_in=0, data_in_power=0, req_ready=0, grant_id=0, holder=0, burst_cnt=0, rr_ptr=0.
REQ-030 Reset assertion mid-transfer discards the slot contents; first grant after release follows REQ-022 from rr_ptr=0.

Structure
REQ-031 Package fifo_arb_pkg holds REQ_NUM/WIDTH/MAX_BURST defaults and typedef struct arb_beat_t {data, power}.
REQ-032 Sub-module fifo_arb_rr_pick: combinational rotating-priority picker (valid vector, start index, exclude mask) returning one-hot grant plus index.

Verification
REQ-033 Req 0..3 valid continuously, data_in_ready=1, MAX_BURST=4 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., one beat per cycle.
REQ-034 Only req 2 valid for 10 beats, data_in_ready=1 -> all 10 accepted back-to-back, grant_id=2, burst_cnt cycles 1..4 without gap.
REQ-035 Slot full, data_in_ready=0 for 5 cycles -> data_in stable, req_ready all 0; ready returns -> same beat accepted, next beat loads that cycle.
REQ-036 Req 1 sends power=0 beat 0xA5 then power=1 beat 0x5A -> FIFO output shows only 0x5A; both beats accepted by arbiter.
REQ-037 rst_n pulsed low while data_in_valid=1 -> data_in_valid=0 immediately; after release req 0 and 3 valid -> req 0 granted first.
REQ-038 Random valid/ready, 20000 beats -> per-requester order preserved, no requester starved beyond (REQ_NUM-1)*MAX_BURST accepted beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and beat payload type for the round-robin FIFO input arbiter.
package fifo_arb_pkg;

   localparam int unsigned ARB_REQ_NUM   = 4;
   localparam int unsigned ARB_WIDTH     = 128;
   localparam int unsigned ARB_MAX_BURST = 4;

   typedef struct packed {
      logic [ARB_WIDTH-1:0] data;
      logic                 power;
   } arb_beat_t;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating-priority picker: first candidate at or after i_start (modulo N),
// with masked-out requesters skipped.
module fifo_arb_rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         i_valid,
   input  logic [$clog2(N)-1:0] i_start,
   input  logic [N-1:0]         i_excl,
   output logic [N-1:0]         o_grant_c,
   output logic [$clog2(N)-1:0] o_idx_c,
   output logic                 o_found_c
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [N-1:0] w_cand;

   assign w_cand = i_valid & ~i_excl;

   always_comb begin
      int unsigned pos;
      o_grant_c = '0;
      o_idx_c   = '0;
      o_found_c = 1'b0;
      pos       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(i_start) + k;
         if (pos >= N) pos = pos - N;
         if (!o_found_c && w_cand[IDX_W'(pos)]) begin
            o_found_c = 1'b1;
            o_idx_c   = IDX_W'(pos);
            o_grant_c = N'(1) << pos;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with burst limit feeding a single-slot register stage
// toward a bypass FIFO input.
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned REQ_NUM   = ARB_REQ_NUM,
   parameter int unsigned WIDTH     = ARB_WIDTH,
   parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [REQ_NUM-1:0]         req_valid,
   input  logic [REQ_NUM*WIDTH-1:0]   req_data,
   input  logic [REQ_NUM-1:0]         req_power,
   output logic [REQ_NUM-1:0]         req_ready,
   output logic                       data_in_valid,
   output logic [WIDTH-1:0]           data_in,
   output logic                       data_in_power,
   input  logic                       data_in_ready,
   output logic [$clog2(REQ_NUM)-1:0] grant_id
);

   localparam int unsigned IDX_W = $clog2(REQ_NUM);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_NUM - 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             power;
   } beat_t;

   logic             r_slot_valid;
   beat_t            r_slot;
   logic [IDX_W-1:0] r_holder;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_grant_id;
   logic [CNT_W-1:0] r_burst_cnt;

   logic               w_load_en;
   logic               w_holder_valid;
   logic               w_burst_full;
   logic               w_keep;
   logic               w_others_valid;
   logic               w_restart;
   logic               w_accept;
   logic               w_pick_found;
   logic [REQ_NUM-1:0] w_holder_oh;
   logic [REQ_NUM-1:0] w_excl;
   logic [REQ_NUM-1:0] w_pick_oh;
   logic [REQ_NUM-1:0] w_grant;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [IDX_W-1:0]   w_next_ptr;
   logic [WIDTH-1:0]   w_req_data [REQ_NUM];

   for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign w_req_data[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Holder keeps the grant until it drops valid or exhausts its burst; a full
   // burst only yields when somebody else is actually waiting.
   assign w_load_en      = ~r_slot_valid | data_in_ready;
   assign w_holder_oh    = REQ_NUM'(1) << r_holder;
   assign w_holder_valid = |(req_valid & w_holder_oh);
   assign w_burst_full   = (r_burst_cnt == CNT_MAX);
   assign w_keep         = w_holder_valid & ~w_burst_full;
   assign w_others_valid = |(req_valid & ~w_holder_oh);
   assign w_excl         = (w_burst_full & w_others_valid) ? w_holder_oh : '0;

   fifo_arb_rr_pick #(
      .N (REQ_NUM)
   ) u_pick (
      .i_valid   (req_valid),
      .i_start   (r_rr_ptr),
      .i_excl    (w_excl),
      .o_grant_c (w_pick_oh),
      .o_idx_c   (w_pick_idx),
      .o_found_c (w_pick_found)
   );

   assign w_grant     = w_keep ? w_holder_oh : w_pick_oh;
   assign w_grant_idx = w_keep ? r_holder : w_pick_idx;
   assign w_accept    = w_load_en & (w_keep | w_pick_found);
   assign w_restart   = w_burst_full & (w_grant_idx == r_holder);
   assign w_next_ptr  = (w_grant_idx == IDX_LAST) ? '0 : w_grant_idx + IDX_W'(1);
   assign req_ready   = (rst_n & w_load_en) ? w_grant : '0;

   // Arbitration state: holder, burst count, round-robin pointer, last grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_holder    <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_grant_id  <= '0;
      end else if (w_load_en) begin
         if (w_accept) begin
            r_grant_id <= w_grant_idx;
            if ((w_grant_idx == r_holder) && !w_restart) begin
               r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else begin
               r_holder    <= w_grant_idx;
               r_burst_cnt <= CNT_W'(1);
               r_rr_ptr    <= w_next_ptr;
            end
         end else if (!w_holder_valid) begin
            r_burst_cnt <= '0;
         end
      end
   end

   // Output slot: reloads whenever it is empty or being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot_valid <= 1'b0;
         r_slot       <= '0;
      end else if (w_load_en) begin
         r_slot_valid <= w_accept;
         if (w_accept) begin
            r_slot <= '{data: w_req_data[w_grant_idx], power: req_power[w_grant_idx]};
         end
      end
   end

   assign data_in_valid = r_slot_valid;
   assign data_in       = r_slot.data;
   assign data_in_power = r_slot.power;
   assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed vector table, corner-case
// sequences and a randomized run against a queue-level reference model.
module tb_fifo_rr_arbiter;
   import fifo_arb_pkg::*;

   localparam int unsigned N     = ARB_REQ_NUM;
   localparam int unsigned W     = ARB_WIDTH;
   localparam int unsigned MB    = ARB_MAX_BURST;
   localparam int unsigned IW    = $clog2(N);
   localparam int          BEATS = 20000;
   localparam int          CYC_MAX = 60000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data = '0;
   logic [N-1:0]     req_power = '0;
   logic [N-1:0]     req_ready;
   logic             data_in_valid;
   logic [W-1:0]     data_in;
   logic             data_in_power;
   logic             data_in_ready = 1'b0;
   logic [IW-1:0]    grant_id;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(
      .REQ_NUM   (N),
      .WIDTH     (W),
      .MAX_BURST (MB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_power     (req_power),
      .req_ready     (req_ready),
      .data_in_valid (data_in_valid),
      .data_in       (data_in),
      .data_in_power (data_in_power),
      .data_in_ready (data_in_ready),
      .grant_id      (grant_id)
   );

   typedef struct {
      logic [N-1:0]  rv;
      logic          rdy;
      logic [N-1:0]  exp_ready;
      logic          exp_dv;
      logic [IW-1:0] exp_gid;
   } vec_t;

   vec_t tbl [12];

   // Reference model state (random phase)
   int        m_holder, m_cnt, m_ptr;
   logic      m_sv;
   arb_beat_t m_slot;
   logic [N-1:0] pend;
   logic [31:0]  seq [N];
   logic [31:0]  out_seq [N];
   int           wait_cnt [N];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] d, input logic p);
      req_data[i*W +: W] = d;
      req_power[i]       = p;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      req_valid     = '0;
      data_in_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Next grant from the arbitration rules, or -1 if nobody can be granted.
   function automatic int model_pick(input logic [N-1:0] v);
      int others;
      int c;
      others = 0;
      if (v[m_holder] && m_cnt < int'(MB)) return m_holder;
      for (int i = 0; i < int'(N); i++) if (i != m_holder && v[i]) others++;
      for (int k = 0; k < int'(N); k++) begin
         c = (m_ptr + k) % int'(N);
         if (v[c] && !(c == m_holder && m_cnt == int'(MB) && others > 0)) return c;
      end
      return -1;
   endfunction

   initial begin
      int g;
      logic ld, acc;
      logic [N-1:0] exp_ready;
      int beats;
      int id;

      // ---------------- reset values ----------------
      req_valid     = 4'b1111;
      data_in_ready = 1'b1;
      #12;
      chk("rst_dv",    W'(data_in_valid), W'(1'b0));
      chk("rst_data",  data_in, '0);
      chk("rst_power", W'(data_in_power), W'(1'b0));
      chk("rst_ready", W'(req_ready), W'(4'b0000));
      chk("rst_gid",   W'(grant_id), W'(2'd0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---------------- vector table ----------------
      for (int i = 0; i < int'(N); i++) set_req(i, W'(32'hD0 + i), 1'b1);
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
      tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      for (int i = 0; i < 12; i++) begin
         req_valid     = tbl[i].rv;
         data_in_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), W'(req_ready), W'(tbl[i].exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_dv", i), W'(data_in_valid), W'(tbl[i].exp_dv));
         chk($sformatf("tbl%0d_gid", i), W'(grant_id), W'(tbl[i].exp_gid));
         if (tbl[i].exp_dv)
            chk($sformatf("tbl%0d_data", i), data_in, W'(32'hD0 + 32'(tbl[i].exp_gid)));
      end

      // ---------------- stall: slot full, FIFO not ready ----------------
      set_req(1, W'(32'h11), 1'b1);
      req_valid     = 4'b0010;
      data_in_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_ready", W'(req_ready), W'(4'b0000));
         @(posedge clk);
         #1;
         chk("stall_dv",   W'(data_in_valid), W'(1'b1));
         chk("stall_data", data_in, W'(32'hD2));
      end
      data_in_ready = 1'b1;
      @(negedge clk);
      chk("unstall_ready", W'(req_ready), W'(4'b0010));
      @(posedge clk);
      #1;
      chk("unstall_data", data_in, W'(32'h11));
      chk("unstall_gid",  W'(grant_id), W'(2'd1));

      // ---------------- power=0 beat is forwarded like any other ----------------
      set_req(1, W'(8'hA5), 1'b0);
      @(negedge clk);
      chk("pwr0_ready", W'(req_ready), W'(4'b0010));
      @(posedge clk);
      #1;
      chk("pwr0_data",  data_in, W'(8'hA5));
      chk("pwr0_power", W'(data_in_power), W'(1'b0));
      set_req(1, W'(8'h5A), 1'b1);
      @(negedge clk);
      chk("pwr1_ready", W'(req_ready), W'(4'b0010));
      @(posedge clk);
      #1;
      chk("pwr1_data",  data_in, W'(8'h5A));
      chk("pwr1_power", W'(data_in_power), W'(1'b1));

      // ---------------- single requester, back-to-back beyond burst ----------------
      req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         set_req(2, W'(32'h200 + k), 1'b1);
         @(negedge clk);
         chk("solo_ready", W'(req_ready), W'(4'b0100));
         @(posedge clk);
         #1;
         chk("solo_data", data_in, W'(32'h200 + k));
         chk("solo_gid",  W'(grant_id), W'(2'd2));
      end

      // ---------------- reset mid-transfer ----------------
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_dv",   W'(data_in_valid), W'(1'b0));
      chk("midrst_data", data_in, '0);
      req_valid = 4'b1001;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_ready", W'(req_ready), W'(4'b0001));
      @(posedge clk);
      #1;
      chk("postrst_gid",  W'(grant_id), W'(2'd0));
      chk("postrst_data", data_in, W'(32'hD0));

      // ---------------- all requesters continuously valid ----------------
      do_reset();
      for (int i = 0; i < int'(N); i++) set_req(i, W'(32'hD0 + i), 1'b1);
      req_valid = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_ready", k), W'(req_ready), W'(N'(1) << ((k / int'(MB)) % int'(N))));
         @(posedge clk);
         #1;
         chk($sformatf("rr%0d_gid", k), W'(grant_id), W'((k / int'(MB)) % int'(N)));
      end

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_holder = 0; m_cnt = 0; m_ptr = 0; m_sv = 1'b0; m_slot = '0;
      pend = '0;
      beats = 0;
      for (int i = 0; i < int'(N); i++) begin
         seq[i] = '0; out_seq[i] = '0; wait_cnt[i] = 0;
      end
      for (int cyc = 0; cyc < CYC_MAX && beats < BEATS && failures < 50; cyc++) begin
         data_in_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < int'(N); i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               set_req(i, W'({8'(i), seq[i]}), 1'($urandom_range(0, 1)));
            end
         end
         req_valid = pend;
         @(negedge clk);
         g   = model_pick(req_valid);
         ld  = !m_sv || data_in_ready;
         acc = ld && (g >= 0);
         exp_ready = acc ? (N'(1) << g) : '0;
         chk("rnd_ready", W'(req_ready), W'(exp_ready));
         chk("rnd_dv", W'(data_in_valid), W'(m_sv));
         if (m_sv) begin
            chk("rnd_data",  data_in, m_slot.data);
            chk("rnd_power", W'(data_in_power), W'(m_slot.power));
         end
         if (data_in_valid && data_in_ready) begin
            id = int'(data_in[39:32]);
            if (id < int'(N)) begin
               chk("rnd_order", W'(data_in[31:0]), W'(out_seq[id]));
               out_seq[id] = out_seq[id] + 32'd1;
            end else begin
               chk("rnd_order_id", W'(id), W'(0));
            end
         end
         @(posedge clk);
         #1;
         if (acc) begin
            for (int i = 0; i < int'(N); i++) if (pend[i] && i != g) wait_cnt[i]++;
            checks++;
            if (wait_cnt[g] > int'((N - 1) * MB)) begin
               failures++;
               $display("FAIL rnd_starve: requester %0d waited %0d beats, limit %0d",
                        g, wait_cnt[g], (N - 1) * MB);
            end
            wait_cnt[g] = 0;
            if (g == m_holder && m_cnt != int'(MB)) begin
               m_cnt++;
            end else begin
               m_holder = g;
               m_cnt    = 1;
               m_ptr    = (g + 1) % int'(N);
            end
            m_slot  = '{data: req_data[g*W +: W], power: req_power[g]};
            pend[g] = 1'b0;
            seq[g]  = seq[g] + 32'd1;
            beats++;
         end else if (ld && !req_valid[m_holder]) begin
            m_cnt = 0;
         end
         if (ld) m_sv = acc;
      end
      checks++;
      if (beats < BEATS) begin
         failures++;
         $display("FAIL rnd_beats: accepted %0d beats, required %0d", beats, BEATS);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
